muldiv_ctrl: RTL
================

// Module: muldiv_ctrl
// PURPOSE
//  Multi-cycle RV32M scheduler beside the execute stage. Accepts one MUL*/DIV*/REM* op from ex
//  (opcode INST_TYPE_R, funct7 = 7'b0000001) and runs an iterative shift-add / restoring-divide FSM.
//  Stalls the pipeline until done, then returns the result and rd address for writeback.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//  clk            in   1     clock
//  rst            in   1     reset, synchronous, active-high
//  start_i        in   1     ex holds an M-op; held with operands stable while stall_o=1
//  funct3_i       in   3     op select: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU (funct3 0..7)
//  op1_i          in   XLEN  rs1 value (dividend / multiplicand)
//  op2_i          in   XLEN  rs2 value (divisor / multiplier)
//  reg_w_addr_i   in   5     rd of the op
//  flush_i        in   1     jump/flush from ctrl; kills the in-flight op
//  stall_o        out  1     hold PC/IF/ID/EX while asserted
//  ready_o        out  1     one-cycle pulse: result_o/reg_w_addr_o valid, write rd
//  result_o       out  XLEN  result, registered
//  reg_w_addr_o   out  5     rd for result, registered
// BEHAVIOUR
//  - Reset: state IDLE; stall_o=0, ready_o=0, result_o=0, reg_w_addr_o=0, counter=0.
//  - States: IDLE, CALC, FIX, DONE.
//  - IDLE: start_i & ~flush_i latches |op1|, |op2|, sign flags, funct3, rd.
//    -> DONE if special case, else -> CALC with counter=0.
//  - CALC: one iteration/cycle.
//    MUL: add-shift on 2*XLEN accumulator.
//    DIV: restoring step on {rem,quot}; rem compared as XLEN+1 bits.
//    -> FIX when counter==XLEN-1.
//  - FIX: negate result as needed, select output half, register result_o. -> DONE.
//  - DONE: ready_o=1, stall_o=0 (pipeline advances this cycle). -> IDLE.
//    A new start_i is accepted in the following IDLE cycle.
//  - stall_o = ~flush_i & ((IDLE & start_i) | CALC | FIX). Combinational, asserted in the start cycle.
//  - Latency: start cycle = cycle 0. Normal ops: CALC cycles 1..32, FIX cycle 33, ready_o cycle 34.
//    Special cases: ready_o cycle 1.
//  - Signedness and output:
//    MUL: low half of the product.
//    MULH: s*s, high half.  MULHSU: rs1 signed * rs2 unsigned, high half.  MULHU: u*u, high half.
//    DIV/REM: quotient sign = s1^s2; remainder sign = dividend sign.
//  - Special cases, resolved without iteration:
//    divisor==0: DIV/DIVU -> all ones; REM/REMU -> op1_i.
//    DIV 0x80000000 / -1 -> 0x80000000; REM -> 0.
//  - flush_i in any state: next state IDLE; ready_o forced 0 that cycle; result_o keeps its old value.
//  - start_i deasserted mid-op without flush: op completes normally (ex contract violation; no error).
//  - rst mid-op: behaves as reset, no ready_o.
//  - result_o/reg_w_addr_o hold their values between DONE pulses.
//    Consumers qualify them with ready_o only.
// STRUCTURE
//  - define.v gains: INST_MUL..INST_REMU funct3 codes, FUNCT7_M = 7'b0000001,
//    MD_IDLE/MD_CALC/MD_FIX/MD_DONE state codes.
//  - Single module holding FSM, 6-bit counter, 2*XLEN+1 working register, sign/op latches.
//  - No sub-module: the iteration datapath is shared between mul and div and is too small to split.
//  - ex routes M-ops here. ctrl ORs stall_o into its stall vector.
// TESTING
//  1. MUL 7 * 0xFFFFFFFD -> stall_o=1 cycles 0..33, ready_o at cycle 34, result 0xFFFFFFEB.
//  2. MULH 0x80000000 * 0x80000000 -> 0x40000000.
//     MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
//     MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF.
//  3. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
//     DIVU 100 / 7 -> 14; REMU -> 2.
//  4. DIVU 0x1234 / 0 -> 0xFFFFFFFF, ready_o at cycle 1.
//     REMU -> 0x1234.
//     DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
//  5. DIV started, flush_i at cycle 10 -> stall_o=0 same cycle, IDLE next, no ready_o.
//     New MUL 3*4 accepted the next cycle -> 12 at +34.
//  6. rst at cycle 20 of a DIV -> all outputs 0 next cycle.
//     Back-to-back MUL, MUL -> second start accepted the cycle after the first ready_o, correct rd each.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - RV32M op codes, FSM states and operand signedness helpers
package muldiv_ctrl_pkg;

  localparam int XLEN_DEF = 32;
  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  localparam logic [2:0] INST_MUL    = 3'd0;
  localparam logic [2:0] INST_MULH   = 3'd1;
  localparam logic [2:0] INST_MULHSU = 3'd2;
  localparam logic [2:0] INST_MULHU  = 3'd3;
  localparam logic [2:0] INST_DIV    = 3'd4;
  localparam logic [2:0] INST_DIVU   = 3'd5;
  localparam logic [2:0] INST_REM    = 3'd6;
  localparam logic [2:0] INST_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  function automatic logic op1_signed(input logic [2:0] f3);
    return (f3 == INST_MUL) || (f3 == INST_MULH) || (f3 == INST_MULHSU) ||
           (f3 == INST_DIV) || (f3 == INST_REM);
  endfunction

  function automatic logic op2_signed(input logic [2:0] f3);
    return (f3 == INST_MUL) || (f3 == INST_MULH) || (f3 == INST_DIV) || (f3 == INST_REM);
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative RV32M multiply/divide scheduler that stalls the pipeline until done
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      reg_w_addr_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      reg_w_addr_o
);

  md_state_e         state, state_nxt;
  logic [5:0]        cnt;
  logic [2*XLEN:0]   acc;
  logic [XLEN-1:0]   opa_q;
  logic [2:0]        f3_q;
  logic              s1_q, s2_q;
  logic [4:0]        rd_q;

  logic              s1, s2, div_zero, div_ovf, special, accept;
  logic [XLEN-1:0]   abs1, abs2, special_res, fix_res;
  logic [XLEN:0]     mul_sum, div_cand, div_diff, divisor_ext;
  logic              div_ge;
  logic [2*XLEN:0]   acc_mul, acc_div;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot, rem;

  assign s1   = op1_signed(funct3_i) & op1_i[XLEN-1];
  assign s2   = op2_signed(funct3_i) & op2_i[XLEN-1];
  assign abs1 = s1 ? -op1_i : op1_i;
  assign abs2 = s2 ? -op2_i : op2_i;

  assign div_zero = funct3_i[2] && (op2_i == '0);
  assign div_ovf  = ((funct3_i == INST_DIV) || (funct3_i == INST_REM)) &&
                    (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
  assign special  = div_zero || div_ovf;
  // funct3[1] separates REM* from DIV* among the divide ops
  assign special_res = funct3_i[1] ? (div_zero ? op1_i : '0)
                                   : (div_zero ? '1 : op1_i);

  assign accept = (state == MD_IDLE) && start_i && !flush_i;

  // Multiply: add multiplicand into the high half when the LSB is set, then shift right
  assign mul_sum = acc[2*XLEN:XLEN] + (acc[0] ? {1'b0, opa_q} : '0);
  assign acc_mul = {1'b0, mul_sum, acc[XLEN-1:1]};

  // Divide: shift {rem,quot} left and subtract the divisor if the 33-bit remainder covers it
  assign divisor_ext = {1'b0, opa_q};
  assign div_cand    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_ge      = div_cand >= divisor_ext;
  assign div_diff    = div_cand - divisor_ext;
  assign acc_div     = {(div_ge ? div_diff : div_cand), acc[XLEN-2:0], div_ge};

  assign prod_s = (s1_q ^ s2_q) ? -acc[2*XLEN-1:0] : acc[2*XLEN-1:0];
  assign quot   = acc[XLEN-1:0];
  assign rem    = acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    case (f3_q)
      INST_MUL:              fix_res = prod_s[XLEN-1:0];
      INST_DIV, INST_DIVU:   fix_res = (s1_q ^ s2_q) ? -quot : quot;
      INST_REM, INST_REMU:   fix_res = s1_q ? -rem : rem;
      default:               fix_res = prod_s[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    ready_o   = 1'b0;
    case (state)
      MD_IDLE: begin
        stall_o = start_i;
        if (accept) state_nxt = special ? MD_DONE : MD_CALC;
      end
      MD_CALC: begin
        stall_o = 1'b1;
        if (cnt == 6'(XLEN-1)) state_nxt = MD_FIX;
      end
      MD_FIX: begin
        stall_o   = 1'b1;
        state_nxt = MD_DONE;
      end
      default: begin
        ready_o   = 1'b1;
        state_nxt = MD_IDLE;
      end
    endcase
    if (flush_i) begin
      state_nxt = MD_IDLE;
      stall_o   = 1'b0;
      ready_o   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      cnt          <= '0;
      opa_q        <= '0;
      f3_q         <= '0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      rd_q         <= '0;
      result_o     <= '0;
      reg_w_addr_o <= '0;
    end else if (accept) begin
      acc   <= {{(XLEN+1){1'b0}}, (funct3_i[2] ? abs1 : abs2)};
      opa_q <= funct3_i[2] ? abs2 : abs1;
      cnt   <= '0;
      f3_q  <= funct3_i;
      s1_q  <= s1;
      s2_q  <= s2;
      rd_q  <= reg_w_addr_i;
      if (special) begin
        result_o     <= special_res;
        reg_w_addr_o <= reg_w_addr_i;
      end
    end else if (state == MD_CALC && !flush_i) begin
      acc <= f3_q[2] ? acc_div : acc_mul;
      cnt <= cnt + 6'd1;
    end else if (state == MD_FIX && !flush_i) begin
      result_o     <= fix_res;
      reg_w_addr_o <= rd_q;
    end
  end

endmodule
